i2s_stereo_tx: RTL and testbench



---
 rtl/i2s_pkg.sv | 18 +
 rtl/i2s_bclk_nco.sv | 41 ++++
 rtl/i2s_stereo_tx.sv | 115 +++++++++++
 tb/tb_i2s_stereo_tx.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2s_pkg.sv
// Shared constants, sample type and bit-clock increment helper for the I2S stereo transmitter.
package i2s_pkg;

    localparam int unsigned FRAME_BITS  = 32;
    localparam int unsigned SAMPLE_BITS = 16;
    localparam int unsigned ACC_WIDTH   = 28;

    typedef struct packed {
        logic [SAMPLE_BITS-1:0] l;
        logic [SAMPLE_BITS-1:0] r;
    } stereo_sample_t;

    // Two BCLK edges per bit, 32 bits per frame.
    function automatic int unsigned bclk_inc(input int unsigned fs);
        return 64 * fs;
    endfunction

endpackage

// File: rtl/i2s_bclk_nco.sv
// Fractional phase accumulator: emits a tick whenever the accumulator wraps past CLKFREQ
// and toggles the bit clock on each tick.
module i2s_bclk_nco
    import i2s_pkg::*;
#(
    parameter int unsigned CLKFREQ = 108_000_000,
    parameter int unsigned INC     = 3_072_000
) (
    input  logic CLK,
    input  logic RESET,
    output logic tick,
    output logic bclk
);

    localparam logic [ACC_WIDTH-1:0] INC_W = ACC_WIDTH'(INC);
    localparam logic [ACC_WIDTH-1:0] LIM_W = ACC_WIDTH'(CLKFREQ);

    logic [ACC_WIDTH-1:0] acc_q, acc_d, sum;
    logic                 bclk_q;

    always_comb begin
        sum   = acc_q + INC_W;
        tick  = (sum >= LIM_W);
        acc_d = tick ? (sum - LIM_W) : sum;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            acc_q  <= '0;
            bclk_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            if (tick) begin
                bclk_q <= ~bclk_q;
            end
        end
    end

    assign bclk = bclk_q;

endmodule

// File: rtl/i2s_stereo_tx.sv
// I2S stereo transmitter: one-deep sample holding register, 32-slot frame serializer.
// Build option I2S_UNDERRUN_ZERO_EN: an underrun frame plays silence instead of repeating.
module i2s_stereo_tx
    import i2s_pkg::*;
#(
    parameter int unsigned CLKFREQ = 108_000_000,
    parameter int unsigned FS      = 48_000
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [15:0] SAMPLE_L,
    input  logic [15:0] SAMPLE_R,
    input  logic        SAMPLE_VALID,
    output logic        SAMPLE_READY,
    output logic        DAC_BCLK,
    output logic        DAC_LRCLK,
    output logic        DAC_DIN,
    output logic        UNDERRUN
);

    logic tick, bclk, fall;

    i2s_bclk_nco #(
        .CLKFREQ (CLKFREQ),
        .INC     (bclk_inc(FS))
    ) u_nco (
        .CLK   (CLK),
        .RESET (RESET),
        .tick  (tick),
        .bclk  (bclk)
    );

    // A tick while BCLK is high drives it low: that is where slot data advances.
    assign fall = tick & bclk;

    logic [4:0]            slot_q, slot_d;
    logic [FRAME_BITS-1:0] shift_q, shift_d, last_q, last_d, frame;
    stereo_sample_t        hold_q, hold_d;
    logic                  hold_full_q, hold_full_d;
    logic                  ready_q, din_q, din_d, lrclk_q, lrclk_d, underrun_q, underrun_d;
    logic                  accept, load;

    always_comb begin
        accept      = SAMPLE_VALID & ready_q;
        load        = 1'b0;
        slot_d      = slot_q;
        shift_d     = shift_q;
        last_d      = last_q;
        din_d       = din_q;
        lrclk_d     = lrclk_q;
        underrun_d  = 1'b0;
        hold_d      = hold_q;
`ifdef I2S_UNDERRUN_ZERO_EN
        frame       = '0;
`else
        frame       = last_q;
`endif
        if (hold_full_q) begin
            frame = hold_q;
        end

        if (fall) begin
            slot_d  = slot_q + 5'd1;
            lrclk_d = (slot_d >= 5'd15) && (slot_d <= 5'd30);
            if (slot_d == 5'd0) begin
                load       = 1'b1;
                underrun_d = ~hold_full_q;
                last_d     = frame;
                din_d      = frame[FRAME_BITS-1];
                shift_d    = {frame[FRAME_BITS-2:0], 1'b0};
            end else begin
                din_d   = shift_q[FRAME_BITS-1];
                shift_d = {shift_q[FRAME_BITS-2:0], 1'b0};
            end
        end

        if (accept) begin
            hold_d.l = SAMPLE_L;
            hold_d.r = SAMPLE_R;
        end
        // An accept can only coincide with a load when the holder was empty (underrun).
        hold_full_d = load ? accept : (hold_full_q | accept);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            slot_q      <= 5'd31;
            shift_q     <= '0;
            last_q      <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            ready_q     <= 1'b0;
            din_q       <= 1'b0;
            lrclk_q     <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            slot_q      <= slot_d;
            shift_q     <= shift_d;
            last_q      <= last_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            ready_q     <= ~hold_full_d;
            din_q       <= din_d;
            lrclk_q     <= lrclk_d;
            underrun_q  <= underrun_d;
        end
    end

    assign SAMPLE_READY = ready_q;
    assign DAC_BCLK     = bclk;
    assign DAC_LRCLK    = lrclk_q;
    assign DAC_DIN      = din_q;
    assign UNDERRUN     = underrun_q;

endmodule

// File: tb/tb_i2s_stereo_tx.sv
// Directed bench for i2s_stereo_tx: an I2S receiver model decodes frames from the pins and
// each scenario task checks decoded data, underrun flags, timing and handshake behaviour.
module tb_i2s_stereo_tx;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic [15:0] SAMPLE_L = '0;
    logic [15:0] SAMPLE_R = '0;
    logic        SAMPLE_VALID = 1'b0;
    logic        SAMPLE_READY, DAC_BCLK, DAC_LRCLK, DAC_DIN, UNDERRUN;

    int n_vec = 0;
    int n_err = 0;

    always #5 CLK = ~CLK;

    i2s_stereo_tx dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .SAMPLE_L     (SAMPLE_L),
        .SAMPLE_R     (SAMPLE_R),
        .SAMPLE_VALID (SAMPLE_VALID),
        .SAMPLE_READY (SAMPLE_READY),
        .DAC_BCLK     (DAC_BCLK),
        .DAC_LRCLK    (DAC_LRCLK),
        .DAC_DIN      (DAC_DIN),
        .UNDERRUN     (UNDERRUN)
    );

    // Receiver model: bits are taken on BCLK rising edges; a bit belongs to the channel that
    // LRCLK showed on the previous rising edge, so the word select leads the data by one bit.
    int          mon_cyc, mon_toggles, mon_lr_rises, mon_hp, mon_hp_min, mon_hp_max;
    int          mon_fdone, mon_urs, mon_cnt;
    bit          mon_bclk_p, mon_lr_p, mon_lr_at_rise, mon_ch_p, mon_seen_fall;
    bit          mon_ur_seen, mon_cur_ur, mon_ch;
    logic [15:0] mon_word, mon_left;
    logic [31:0] mon_frame [512];
    bit          mon_fur [512];

    always begin
        @(posedge CLK);
        #1;
        if (RESET) begin
            mon_cyc = 0; mon_toggles = 0; mon_lr_rises = 0; mon_hp = 0;
            mon_hp_min = 1000; mon_hp_max = 0; mon_fdone = 0; mon_urs = 0; mon_cnt = 0;
            mon_bclk_p = 1'b0; mon_lr_p = 1'b0; mon_lr_at_rise = 1'b0; mon_ch_p = 1'b1;
            mon_seen_fall = 1'b0; mon_ur_seen = 1'b0; mon_cur_ur = 1'b0;
            mon_word = '0; mon_left = '0;
        end else begin
            mon_cyc++;
            mon_hp++;
            if (DAC_BCLK !== mon_bclk_p) begin
                mon_toggles++;
                if (mon_hp < mon_hp_min) mon_hp_min = mon_hp;
                if (mon_hp > mon_hp_max) mon_hp_max = mon_hp;
                mon_hp = 0;
            end
            if (DAC_LRCLK && !mon_lr_p) mon_lr_rises++;
            if (UNDERRUN) begin
                mon_ur_seen = 1'b1;
                mon_urs++;
            end
            if (!DAC_BCLK && mon_bclk_p) mon_seen_fall = 1'b1;
            if (DAC_BCLK && !mon_bclk_p) begin
                if (mon_seen_fall) begin
                    mon_ch = mon_lr_at_rise;
                    if (mon_ch != mon_ch_p) begin
                        mon_cnt = 0;
                        if (!mon_ch) begin
                            mon_cur_ur  = mon_ur_seen;
                            mon_ur_seen = 1'b0;
                        end
                    end
                    mon_word = {mon_word[14:0], DAC_DIN};
                    mon_cnt++;
                    if (mon_cnt == 16) begin
                        if (!mon_ch) begin
                            mon_left = mon_word;
                        end else begin
                            mon_frame[mon_fdone & 511] = {mon_left, mon_word};
                            mon_fur[mon_fdone & 511]   = mon_cur_ur;
                            mon_fdone++;
                        end
                    end
                    mon_ch_p = mon_ch;
                end
                mon_lr_at_rise = DAC_LRCLK;
            end
            mon_bclk_p = DAC_BCLK;
            mon_lr_p   = DAC_LRCLK;
        end
    end

    task automatic timeout_fail(input string what);
        n_vec++;
        n_err++;
        $display("FAIL %s: wait expired, got no event, required one", what);
    endtask

    // Waits for LRCLK to reach the given level through a transition.
    task automatic wait_lr(input bit level, output bit ok);
        bit prev;
        ok   = 1'b0;
        prev = DAC_LRCLK;
        for (int i = 0; i < 5000; i++) begin
            @(negedge CLK);
            if (prev == !level && DAC_LRCLK == level) begin
                ok = 1'b1;
                break;
            end
            prev = DAC_LRCLK;
        end
        if (!ok) timeout_fail("wait_lrclk");
    endtask

    // Offers a pair and returns at the negedge after acceptance, VALID left high.
    task automatic send(input logic [15:0] l, input logic [15:0] r, output int waited);
        SAMPLE_L     = l;
        SAMPLE_R     = r;
        SAMPLE_VALID = 1'b1;
        waited       = 0;
        while (SAMPLE_READY !== 1'b1 && waited < 5000) begin
            @(negedge CLK);
            waited++;
        end
        if (SAMPLE_READY !== 1'b1) begin
            timeout_fail("send_ready");
        end else begin
            @(posedge CLK);
            @(negedge CLK);
            n_vec++;
            if (SAMPLE_READY !== 1'b0) begin
                n_err++;
                $display("FAIL ready_after_accept: got %b required 0", SAMPLE_READY);
            end
        end
    endtask

    task automatic wait_done(input int target);
        for (int i = 0; i < 12000 && mon_fdone <= target; i++) @(negedge CLK);
        if (mon_fdone <= target) timeout_fail("wait_frame");
    endtask

    task automatic check_frame(input string name, input int idx, input logic [31:0] exp_data,
                               input bit exp_ur);
        n_vec++;
        if (mon_frame[idx & 511] !== exp_data) begin
            n_err++;
            $display("FAIL %s_data: got %h required %h", name, mon_frame[idx & 511], exp_data);
        end
        n_vec++;
        if (mon_fur[idx & 511] !== exp_ur) begin
            n_err++;
            $display("FAIL %s_underrun: got %b required %b", name, mon_fur[idx & 511], exp_ur);
        end
    endtask

    task automatic check_val(input string name, input int got, input int exp_val);
        n_vec++;
        if (got !== exp_val) begin
            n_err++;
            $display("FAIL %s: got %0d required %0d", name, got, exp_val);
        end
    endtask

    task automatic test_reset;
        RESET        = 1'b1;
        SAMPLE_VALID = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            n_vec++;
            if ({DAC_BCLK, DAC_LRCLK, DAC_DIN, UNDERRUN, SAMPLE_READY} !== 5'b00000) begin
                n_err++;
                $display("FAIL reset_outputs cycle %0d: got %b required 00000", i,
                         {DAC_BCLK, DAC_LRCLK, DAC_DIN, UNDERRUN, SAMPLE_READY});
            end
        end
        RESET = 1'b0;
        @(negedge CLK);
        check_val("ready_after_reset", int'(SAMPLE_READY), 1);
    endtask

    // 27_000 cycles is a quarter millisecond: 768 BCLK edges and 12 word-clock periods.
    task automatic test_rate;
        for (int i = 0; i < 30000 && mon_cyc < 27000; i++) @(negedge CLK);
        check_val("rate_cycles", mon_cyc, 27000);
        check_val("rate_bclk_toggles", mon_toggles, 768);
        check_val("rate_lrclk_rises", mon_lr_rises, 12);
        check_val("rate_halfperiod_min", mon_hp_min, 35);
        check_val("rate_halfperiod_max", mon_hp_max, 36);
    endtask

    task automatic test_data;
        bit ok;
        int t, u0, w;
        wait_lr(1'b0, ok);
        t  = mon_fdone + 1;
        u0 = mon_urs;
        send(16'h8001, 16'h7FFE, w);
        SAMPLE_VALID = 1'b0;
        wait_done(t);
        check_frame("data", t, 32'h8001_7FFE, 1'b0);
        check_val("data_underruns", mon_urs - u0, 0);
        check_val("data_ready_after_load", int'(SAMPLE_READY), 1);
    endtask

    task automatic test_underrun;
        bit ok;
        int t, u0, w;
        logic [31:0] replay;
`ifdef I2S_UNDERRUN_ZERO_EN
        replay = 32'h0000_0000;
`else
        replay = 32'h1234_5678;
`endif
        wait_lr(1'b0, ok);
        t  = mon_fdone + 1;
        u0 = mon_urs;
        send(16'h1234, 16'h5678, w);
        SAMPLE_VALID = 1'b0;
        wait_done(t + 1);
        check_frame("underrun_first", t, 32'h1234_5678, 1'b0);
        check_frame("underrun_replay", t + 1, replay, 1'b1);
        check_val("underrun_pulses", mon_urs - u0, 1);
    endtask

    task automatic test_back_to_back;
        bit ok;
        int t, u0, w0, w1, w2;
        wait_lr(1'b0, ok);
        t  = mon_fdone + 1;
        u0 = mon_urs;
        send(16'h1111, 16'h2222, w0);
        send(16'h3333, 16'h4444, w1);
        send(16'h5555, 16'h6666, w2);
        SAMPLE_VALID = 1'b0;
        // Consecutive accepts are one frame (2250 +/- 1 cycles) apart.
        n_vec++;
        if (w2 < 2245 || w2 > 2252) begin
            n_err++;
            $display("FAIL b2b_ready_gap: got %0d cycles required 2245..2252", w2);
        end
        wait_done(t + 2);
        check_frame("b2b_0", t, 32'h1111_2222, 1'b0);
        check_frame("b2b_1", t + 1, 32'h3333_4444, 1'b0);
        check_frame("b2b_2", t + 2, 32'h5555_6666, 1'b0);
        check_val("b2b_underruns", mon_urs - u0, 0);
    endtask

    task automatic test_reset_mid;
        bit ok;
        bit prevb;
        int w, nf;
        wait_lr(1'b0, ok);
        send(16'hAAAA, 16'h5555, w);
        send(16'hCAFE, 16'hBEEF, w);
        SAMPLE_VALID = 1'b0;
        wait_lr(1'b1, ok);
        // LRCLK rose at slot 15; five more falling edges reach slot 20.
        nf    = 0;
        prevb = DAC_BCLK;
        for (int i = 0; i < 400 && nf < 5; i++) begin
            @(negedge CLK);
            if (prevb && !DAC_BCLK) nf++;
            prevb = DAC_BCLK;
        end
        check_val("mid_slot20_reached", nf, 5);
        check_val("mid_lrclk_before", int'(DAC_LRCLK), 1);
        RESET = 1'b1;
        @(negedge CLK);
        n_vec++;
        if ({DAC_BCLK, DAC_LRCLK, DAC_DIN, UNDERRUN, SAMPLE_READY} !== 5'b00000) begin
            n_err++;
            $display("FAIL mid_reset_outputs: got %b required 00000",
                     {DAC_BCLK, DAC_LRCLK, DAC_DIN, UNDERRUN, SAMPLE_READY});
        end
        @(negedge CLK);
        RESET = 1'b0;
        @(negedge CLK);
        check_val("mid_ready_after_release", int'(SAMPLE_READY), 1);
        wait_done(0);
        check_frame("mid_first_frame", 0, 32'h0000_0000, 1'b1);
    endtask

    initial begin
        test_reset();
        test_rate();
        test_data();
        test_underrun();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
